// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - instruction memory read bus and decoder handshake bundle
interface pc_fetch_unit_if;
    // instruction memory read channel
    logic        mem_rd_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rd_data;
    // decoder channel
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    // fetch unit side
    modport master (
        output mem_rd_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rd_data,
        output instr_valid,
        input  instr_ready,
        output instr,
        output instr_pc
    );

    // memory plus decoder side
    modport slave (
        input  mem_rd_req,
        input  mem_addr,
        output mem_ack,
        output mem_rd_data,
        input  instr_valid,
        output instr_ready,
        input  instr,
        input  instr_pc
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter and single-outstanding instruction fetch
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt,
    input  logic              branch_valid,
    input  logic [31:0]       branch_target,
    pc_fetch_unit_if.master   bus,
    output logic [31:0]       pc
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_DRAIN,
        S_HOLD
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        req_q;
    logic [31:0] addr_q;
    logic        valid_q;
    logic [31:0] instr_q;
    logic [31:0] instr_pc_q;

    logic [31:0] pc_next;
    logic        req_next;
    logic [31:0] addr_next;
    logic        valid_next;
    logic [31:0] instr_next;
    logic [31:0] instr_pc_next;

    // Redirect targets are always word aligned.
    logic [31:0] branch_pc;
    assign branch_pc = {branch_target[31:2], 2'b00};

    // Word increment: each byte chunk precomputes its +1, and a chunk takes
    // it only when every lower chunk is all ones (carry-select).
    logic [29:0] word;
    logic [7:0]  inc0;
    logic [7:0]  inc1;
    logic [7:0]  inc2;
    logic [5:0]  inc3;
    logic        carry1;
    logic        carry2;
    logic        carry3;
    logic [31:0] pc_inc;

    assign word   = pc[31:2];
    assign inc0   = word[7:0]   + 8'd1;
    assign inc1   = word[15:8]  + 8'd1;
    assign inc2   = word[23:16] + 8'd1;
    assign inc3   = word[29:24] + 6'd1;
    assign carry1 = &word[7:0];
    assign carry2 = carry1 & (&word[15:8]);
    assign carry3 = carry2 & (&word[23:16]);
    assign pc_inc = {carry3 ? inc3 : word[29:24],
                     carry2 ? inc2 : word[23:16],
                     carry1 ? inc1 : word[15:8],
                     inc0,
                     2'b00};

    assign bus.mem_rd_req = req_q;
    assign bus.mem_addr   = addr_q;
    assign bus.instr_valid = valid_q;
    assign bus.instr      = instr_q;
    assign bus.instr_pc   = instr_pc_q;

    // State and datapath registers; reset abandons any outstanding request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_FETCH;
            pc         <= RESET_PC;
            req_q      <= 1'b0;
            addr_q     <= 32'h0;
            valid_q    <= 1'b0;
            instr_q    <= 32'h0;
            instr_pc_q <= 32'h0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            req_q      <= req_next;
            addr_q     <= addr_next;
            valid_q    <= valid_next;
            instr_q    <= instr_next;
            instr_pc_q <= instr_pc_next;
        end
    end

    // Next-state and next-datapath values; a redirect wins over halt, ack and ready.
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        req_next      = 1'b0;
        addr_next     = addr_q;
        valid_next    = valid_q;
        instr_next    = instr_q;
        instr_pc_next = instr_pc_q;

        case (state)
            S_FETCH: begin
                if (branch_valid) begin
                    pc_next = branch_pc;
                end else if (!halt) begin
                    req_next   = 1'b1;
                    addr_next  = pc;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (branch_valid) begin
                    pc_next    = branch_pc;
                    state_next = bus.mem_ack ? S_FETCH : S_DRAIN;
                end else if (bus.mem_ack) begin
                    instr_next    = bus.mem_rd_data;
                    instr_pc_next = pc;
                    valid_next    = 1'b1;
                    pc_next       = pc_inc;
                    state_next    = S_HOLD;
                end
            end
            S_DRAIN: begin
                if (branch_valid) begin
                    pc_next = branch_pc;
                end
                if (bus.mem_ack) begin
                    state_next = S_FETCH;
                end
            end
            S_HOLD: begin
                if (branch_valid) begin
                    valid_next = 1'b0;
                    pc_next    = branch_pc;
                    state_next = S_FETCH;
                end else if (bus.instr_ready) begin
                    valid_next = 1'b0;
                    state_next = S_FETCH;
                end
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

endmodule
